// File: rtl/sp_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_arb_pkg
// Shared types, constants and the round-robin pick function for the
// single-port RAM arbiter (sp_ram_arbiter) and its arbiter core (rr_arbiter).
// No ports: package only.
// -----------------------------------------------------------------------------
package sp_ram_arb_pkg;

   localparam int RAM_DATA_W = 64;
   localparam int RAM_BYTES  = 8;
   localparam int MAX_PORTS  = 8;
   localparam int IDX_W      = 3;
   localparam int ADDR_W_DEF = 10;

   // One RAM command at the default address width.
   typedef struct packed {
      logic                  we;
      logic [RAM_BYTES-1:0]  ben;
      logic [ADDR_W_DEF-1:0] addr;
      logic [RAM_DATA_W-1:0] wdata;
   } ram_req_t;

   // One entry of the response pipeline: an access was issued, and by whom.
   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } rsp_tag_t;

   // First requesting port at or after prio, wrapping modulo n.
   // Returns 0 when nothing requests, so idle muxes fall back to port 0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                input logic [IDX_W-1:0]     prio,
                                                input int                   n);
      int               idx;
      logic [IDX_W-1:0] idx_s;
      logic             found;
      rr_pick = '0;
      found   = 1'b0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         idx   = (int'(prio) + i) % n;
         idx_s = IDX_W'(idx);
         if (!found && (i < n) && req[idx_s]) begin
            rr_pick = idx_s;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// N-input round-robin arbiter with a combinational grant and a registered
// priority pointer that moves to (winner+1) mod N after every grant.
// Ports:
//   Clk_CI     in  clock
//   Rst_RBI    in  synchronous active-low reset; also masks all requests
//   Req_SI     in  [N] requests
//   Gnt_SO     out [N] one-hot grant (same cycle as request)
//   Valid_SO   out any grant issued this cycle
//   Winner_DO  out index of the granted port (0 when idle)
// -----------------------------------------------------------------------------
module rr_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic             Clk_CI,
   input  logic             Rst_RBI,
   input  logic [N-1:0]     Req_SI,
   output logic [N-1:0]     Gnt_SO,
   output logic             Valid_SO,
   output logic [IDX_W-1:0] Winner_DO
);

   logic [IDX_W-1:0]     r_prio;
   logic [MAX_PORTS-1:0] w_req;

   // Requests are ignored while reset is held, so nothing is granted then.
   always_comb begin
      // NOTE: every always_comb output gets a default first; no path can infer a latch.
      w_req = '0;
      if (Rst_RBI) w_req[N-1:0] = Req_SI;
   end

   assign Valid_SO  = |w_req;
   assign Winner_DO = rr_pick(w_req, r_prio, N);

   for (genvar g = 0; g < N; g++) begin : g_gnt
      assign Gnt_SO[g] = Valid_SO && (Winner_DO == IDX_W'(g));
   end

   always_ff @(posedge Clk_CI) begin
      // NOTE: state uses <= so every flop samples its pre-edge inputs.
      if (!Rst_RBI)      r_prio <= '0;
      else if (Valid_SO) r_prio <= (Winner_DO == IDX_W'(N-1)) ? '0 : Winner_DO + 1'b1;
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sp_ram_arbiter
// Shares one synchronous single-port 64-bit byte-enable RAM among N_PORTS
// requesters: round-robin grant, command mux to the RAM pins, and a
// RAM_LAT-deep tag pipeline that returns a one-hot response strobe per access.
// Ports:
//   Clk_CI, Rst_RBI           clock, synchronous active-low reset
//   Req_SI, WrEn_SI           [N] request, write(1)/read(0)
//   BEn_SI, Addr_DI, WrData_DI per-port byte enables, word address, write data
//   Gnt_SO                    [N] one-hot grant, combinational
//   RValid_SO, RData_DO       [N] one-hot response strobe, shared read data
//   RamCSel_SO .. RamWrData_DO to the RAM macro pins
//   RamRdData_DI              from the RAM read-data pins
// -----------------------------------------------------------------------------
module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int N_PORTS    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int OUT_REGS   = 0
) (
   input  logic                                Clk_CI,
   input  logic                                Rst_RBI,
   input  logic [N_PORTS-1:0]                  Req_SI,
   input  logic [N_PORTS-1:0]                  WrEn_SI,
   input  logic [N_PORTS-1:0][RAM_BYTES-1:0]   BEn_SI,
   input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]  Addr_DI,
   input  logic [N_PORTS-1:0][RAM_DATA_W-1:0]  WrData_DI,
   output logic [N_PORTS-1:0]                  Gnt_SO,
   output logic [N_PORTS-1:0]                  RValid_SO,
   output logic [RAM_DATA_W-1:0]               RData_DO,
   output logic                                RamCSel_SO,
   output logic                                RamWrEn_SO,
   output logic [RAM_BYTES-1:0]                RamBEn_SO,
   output logic [ADDR_WIDTH-1:0]               RamAddr_DO,
   output logic [RAM_DATA_W-1:0]               RamWrData_DO,
   input  logic [RAM_DATA_W-1:0]               RamRdData_DI
);

   localparam int RAM_LAT = 1 + OUT_REGS;

   typedef struct packed {
      logic                  we;
      logic [RAM_BYTES-1:0]  ben;
      logic [ADDR_WIDTH-1:0] addr;
      logic [RAM_DATA_W-1:0] wdata;
   } cmd_t;

   logic             w_any;
   logic [IDX_W-1:0] w_winner;
   cmd_t             w_cmd_c [N_PORTS];
   cmd_t             w_cmd;
   rsp_tag_t         r_pipe  [RAM_LAT];
   rsp_tag_t         w_tail;

   rr_arbiter #(.N(N_PORTS)) u_arb (
      .Clk_CI    (Clk_CI),
      .Rst_RBI   (Rst_RBI),
      .Req_SI    (Req_SI),
      .Gnt_SO    (Gnt_SO),
      .Valid_SO  (w_any),
      .Winner_DO (w_winner)
   );

   // Mux chain keyed on the winner index; port 0 is the fallback, which also
   // makes it the source of address/data when nobody requests.
   assign w_cmd_c[0] = {WrEn_SI[0], BEn_SI[0], Addr_DI[0], WrData_DI[0]};
   for (genvar g = 1; g < N_PORTS; g++) begin : g_mux
      assign w_cmd_c[g] = (w_winner == IDX_W'(g)) ?
                          {WrEn_SI[g], BEn_SI[g], Addr_DI[g], WrData_DI[g]} : w_cmd_c[g-1];
   end
   assign w_cmd = w_cmd_c[N_PORTS-1];

   assign RamCSel_SO   = w_any;
   assign RamWrEn_SO   = w_any & w_cmd.we;
   assign RamBEn_SO    = w_any ? w_cmd.ben : '0;
   assign RamAddr_DO   = w_cmd.addr;
   assign RamWrData_DO = w_cmd.wdata;

   // Tag pipeline: stage 0 records this cycle's issue, the tail lines up with
   // the RAM's read data.
   always_ff @(posedge Clk_CI) begin
      // NOTE: only this small tag pipeline is reset; the RAM array never is,
      // the RAM resets its own output stage from the same reset.
      if (!Rst_RBI) r_pipe[0] <= '0;
      else          r_pipe[0] <= '{vld: w_any, idx: w_winner};
   end

   for (genvar k = 1; k < RAM_LAT; k++) begin : g_pipe
      always_ff @(posedge Clk_CI) begin
         if (!Rst_RBI) r_pipe[k] <= '0;
         else          r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign w_tail = r_pipe[RAM_LAT-1];

   // Masked by reset as well, so a response due in the reset cycle is dropped.
   for (genvar g = 0; g < N_PORTS; g++) begin : g_rvld
      assign RValid_SO[g] = Rst_RBI && w_tail.vld && (w_tail.idx == IDX_W'(g));
   end

   assign RData_DO = RamRdData_DI;

`ifndef SYNTHESIS
   a_gnt_onehot : assert property (@(posedge Clk_CI) $onehot0(Gnt_SO));
   a_gnt_req    : assert property (@(posedge Clk_CI) (Gnt_SO & ~Req_SI) == '0);
   a_rvld_oh    : assert property (@(posedge Clk_CI) $onehot0(RValid_SO));
   a_out_regs   : assert property (@(posedge Clk_CI) (OUT_REGS == 0) || (OUT_REGS == 1));
   a_n_ports    : assert property (@(posedge Clk_CI) (N_PORTS >= 2) && (N_PORTS <= 8));
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_arbiter
// Directed bench: instance A (3 ports, OUT_REGS=0) and instance B (2 ports,
// OUT_REGS=1), each in front of a behavioural write-first byte-lane RAM.
// Inputs change 1 time unit after the rising edge, outputs are sampled 3 units
// after it.
// -----------------------------------------------------------------------------
module tb_sp_ram_arbiter;

   localparam logic [63:0] D0  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] DA5 = 64'hA5A5_5A5A_C3C3_3C3C;
   localparam logic [63:0] DBE = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] D1  = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D2  = 64'h5555_6666_7777_8888;
   localparam logic [63:0] D3  = 64'h9999_AAAA_BBBB_CCCC;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp;
   int n_mis;

   // ---------------- instance A: N=3, OUT_REGS=0 ----------------
   logic [2:0]       a_req, a_we, a_gnt, a_rvld;
   logic [2:0][7:0]  a_ben;
   logic [2:0][9:0]  a_addr;
   logic [2:0][63:0] a_wd;
   logic [63:0]      a_rdata, a_ram_wd, a_ram_rd;
   logic             a_csel, a_ram_we;
   logic [7:0]       a_ram_ben;
   logic [9:0]       a_ram_addr;
   logic [63:0]      mem_a [1024];

   sp_ram_arbiter #(.N_PORTS(3), .ADDR_WIDTH(10), .OUT_REGS(0)) u_dut_a (
      .Clk_CI       (clk),
      .Rst_RBI      (rst_n),
      .Req_SI       (a_req),
      .WrEn_SI      (a_we),
      .BEn_SI       (a_ben),
      .Addr_DI      (a_addr),
      .WrData_DI    (a_wd),
      .Gnt_SO       (a_gnt),
      .RValid_SO    (a_rvld),
      .RData_DO     (a_rdata),
      .RamCSel_SO   (a_csel),
      .RamWrEn_SO   (a_ram_we),
      .RamBEn_SO    (a_ram_ben),
      .RamAddr_DO   (a_ram_addr),
      .RamWrData_DO (a_ram_wd),
      .RamRdData_DI (a_ram_rd)
   );

   always @(posedge clk) begin
      if (!rst_n) a_ram_rd <= '0;
      else if (a_csel) begin
         for (int b = 0; b < 8; b++) begin
            if (a_ram_we && a_ram_ben[b]) begin
               mem_a[a_ram_addr][b*8 +: 8] <= a_ram_wd[b*8 +: 8];
               a_ram_rd[b*8 +: 8]          <= a_ram_wd[b*8 +: 8];
            end else begin
               a_ram_rd[b*8 +: 8]          <= mem_a[a_ram_addr][b*8 +: 8];
            end
         end
      end
   end

   // ---------------- instance B: N=2, OUT_REGS=1 ----------------
   logic [1:0]       b_req, b_we, b_gnt, b_rvld;
   logic [1:0][7:0]  b_ben;
   logic [1:0][9:0]  b_addr;
   logic [1:0][63:0] b_wd;
   logic [63:0]      b_rdata, b_ram_wd, b_ram_rd, b_core;
   logic             b_csel, b_ram_we;
   logic [7:0]       b_ram_ben;
   logic [9:0]       b_ram_addr;
   logic [63:0]      mem_b [1024];

   sp_ram_arbiter #(.N_PORTS(2), .ADDR_WIDTH(10), .OUT_REGS(1)) u_dut_b (
      .Clk_CI       (clk),
      .Rst_RBI      (rst_n),
      .Req_SI       (b_req),
      .WrEn_SI      (b_we),
      .BEn_SI       (b_ben),
      .Addr_DI      (b_addr),
      .WrData_DI    (b_wd),
      .Gnt_SO       (b_gnt),
      .RValid_SO    (b_rvld),
      .RData_DO     (b_rdata),
      .RamCSel_SO   (b_csel),
      .RamWrEn_SO   (b_ram_we),
      .RamBEn_SO    (b_ram_ben),
      .RamAddr_DO   (b_ram_addr),
      .RamWrData_DO (b_ram_wd),
      .RamRdData_DI (b_ram_rd)
   );

   always @(posedge clk) begin
      if (!rst_n) begin
         b_core   <= '0;
         b_ram_rd <= '0;
      end else begin
         b_ram_rd <= b_core;
         if (b_csel) begin
            for (int b = 0; b < 8; b++) begin
               if (b_ram_we && b_ram_ben[b]) begin
                  mem_b[b_ram_addr][b*8 +: 8] <= b_ram_wd[b*8 +: 8];
                  b_core[b*8 +: 8]            <= b_ram_wd[b*8 +: 8];
               end else begin
                  b_core[b*8 +: 8]            <= mem_b[b_ram_addr][b*8 +: 8];
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic a_set(input int p, input logic we, input logic [7:0] ben,
                        input logic [9:0] addr, input logic [63:0] wd);
      a_we[p]   = we;
      a_ben[p]  = ben;
      a_addr[p] = addr;
      a_wd[p]   = wd;
   endtask

   task automatic b_set(input int p, input logic we, input logic [7:0] ben,
                        input logic [9:0] addr, input logic [63:0] wd);
      b_we[p]   = we;
      b_ben[p]  = ben;
      b_addr[p] = addr;
      b_wd[p]   = wd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, limit 100000");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] rr_exp [3];
      rr_exp = '{D0, DBE, DA5};
      n_cmp  = 0;
      n_mis  = 0;

      // Reset with every port requesting writes: nothing may leak out.
      rst_n  = 1'b0;
      a_req  = '1; a_we = '1; a_ben = '1; a_addr = '0; a_wd = '0;
      b_req  = '1; b_we = '1; b_ben = '1; b_addr = '0; b_wd = '0;
      repeat (2) tick();
      settle();
      check("rst_gnt_a",  a_gnt,     3'b000);
      check("rst_csel_a", a_csel,    1'b0);
      check("rst_we_a",   a_ram_we,  1'b0);
      check("rst_ben_a",  a_ram_ben, 8'h00);
      check("rst_rvld_a", a_rvld,    3'b000);
      check("rst_gnt_b",  b_gnt,     2'b00);
      check("rst_csel_b", b_csel,    1'b0);

      tick();
      rst_n = 1'b1;
      a_req = '0; a_we = '0; a_ben = '0;
      b_req = '0; b_we = '0; b_ben = '0;

      // Single port: write then read same address.
      tick();
      a_req = 3'b001;
      a_set(0, 1'b1, 8'hFF, 10'd5, D0);
      settle();
      check("wr_gnt",   a_gnt,      3'b001);
      check("wr_csel",  a_csel,     1'b1);
      check("wr_we",    a_ram_we,   1'b1);
      check("wr_addr",  a_ram_addr, 10'd5);
      check("wr_ben",   a_ram_ben,  8'hFF);
      check("wr_wdata", a_ram_wd,   D0);
      tick();
      a_set(0, 1'b0, 8'hFF, 10'd5, 64'd0);
      settle();
      check("rd_gnt",   a_gnt,    3'b001);
      check("rd_we",    a_ram_we, 1'b0);
      check("wr_rvld",  a_rvld,   3'b001);
      tick();
      a_req = '0;
      settle();
      check("rd_rvld",  a_rvld,    3'b001);
      check("rd_data",  a_rdata,   D0);
      check("idle_csel", a_csel,   1'b0);
      check("idle_ben", a_ram_ben, 8'h00);
      check("idle_we",  a_ram_we,  1'b0);

      // Byte enables plus hold-until-granted (pointer is at port 1 now).
      tick();
      a_req = 3'b110;
      a_set(1, 1'b1, 8'hFF, 10'd7, 64'd0);
      a_set(2, 1'b1, 8'hFF, 10'd9, DA5);
      settle();
      check("be_s0_gnt",  a_gnt,  3'b010);
      check("be_s0_rvld", a_rvld, 3'b000);
      tick();
      a_set(1, 1'b1, 8'h0F, 10'd7, '1);
      settle();
      check("be_s1_gnt",  a_gnt,  3'b100);
      check("be_s1_rvld", a_rvld, 3'b010);
      tick();
      a_req = 3'b010;
      settle();
      check("be_s2_gnt",  a_gnt,     3'b010);
      check("be_s2_ben",  a_ram_ben, 8'h0F);
      check("be_s2_rvld", a_rvld,    3'b100);
      tick();
      a_set(1, 1'b0, 8'hFF, 10'd7, 64'd0);
      settle();
      check("be_s3_gnt",  a_gnt,  3'b010);
      check("be_s3_rvld", a_rvld, 3'b010);
      tick();
      a_req = '0;
      settle();
      check("be_s4_rvld", a_rvld,  3'b010);
      check("be_s4_data", a_rdata, DBE);
      tick();
      settle();
      check("be_s5_rvld", a_rvld,  3'b000);

      // Round robin from reset, all three ports reading.
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a_req = 3'b111;
      a_set(0, 1'b0, 8'hFF, 10'd5, 64'd0);
      a_set(1, 1'b0, 8'hFF, 10'd7, 64'd0);
      a_set(2, 1'b0, 8'hFF, 10'd9, 64'd0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         if (k == 9) a_req = '0;
         settle();
         check($sformatf("rr_gnt_%0d", k), a_gnt, (k < 9) ? (3'b001 << (k % 3)) : 3'b000);
         if (k > 0) begin
            check($sformatf("rr_rvld_%0d", k), a_rvld, 3'b001 << ((k - 1) % 3));
            check($sformatf("rr_data_%0d", k), a_rdata, rr_exp[(k - 1) % 3]);
         end else begin
            check("rr_rvld_0", a_rvld, 3'b000);
         end
      end

      // Contention between ports 0 and 1 (pointer back at 0).
      tick();
      a_req = 3'b011;
      settle();
      check("ct_t0_gnt",  a_gnt,  3'b001);
      check("ct_t0_rvld", a_rvld, 3'b000);
      tick();
      a_req = 3'b010;
      settle();
      check("ct_t1_gnt",  a_gnt,   3'b010);
      check("ct_t1_rvld", a_rvld,  3'b001);
      check("ct_t1_data", a_rdata, D0);
      tick();
      a_req = 3'b011;
      settle();
      check("ct_t2_gnt",  a_gnt,   3'b001);
      check("ct_t2_rvld", a_rvld,  3'b010);
      check("ct_t2_data", a_rdata, DBE);

      // Reset while a read is in flight.
      tick();
      a_req = 3'b010;
      settle();
      check("mr_t0_gnt",  a_gnt,  3'b010);
      check("mr_t0_rvld", a_rvld, 3'b001);
      tick();
      rst_n = 1'b0;
      a_req = 3'b111;
      settle();
      check("mr_t1_gnt",  a_gnt,  3'b000);
      check("mr_t1_csel", a_csel, 1'b0);
      check("mr_t1_rvld", a_rvld, 3'b000);
      tick();
      rst_n = 1'b1;
      settle();
      check("mr_t2_gnt",  a_gnt,  3'b001);
      check("mr_t2_rvld", a_rvld, 3'b000);
      tick();
      a_req = '0;
      settle();
      check("mr_t3_gnt",  a_gnt,   3'b000);
      check("mr_t3_rvld", a_rvld,  3'b001);
      check("mr_t3_data", a_rdata, D0);
      tick();
      settle();
      check("mr_t4_rvld", a_rvld,  3'b000);

      // OUT_REGS=1: three writes then three reads, responses two cycles later.
      tick();
      b_req = 2'b01;
      b_set(0, 1'b1, 8'hFF, 10'd1, D1);
      settle();
      check("b_c0_gnt",  b_gnt,  2'b01);
      check("b_c0_rvld", b_rvld, 2'b00);
      tick();
      b_req = 2'b10;
      b_set(1, 1'b1, 8'hFF, 10'd2, D2);
      settle();
      check("b_c1_gnt",  b_gnt,  2'b10);
      check("b_c1_rvld", b_rvld, 2'b00);
      tick();
      b_req = 2'b01;
      b_set(0, 1'b1, 8'hFF, 10'd3, D3);
      settle();
      check("b_c2_gnt",  b_gnt,  2'b01);
      check("b_c2_rvld", b_rvld, 2'b01);
      tick();
      b_set(0, 1'b0, 8'hFF, 10'd1, 64'd0);
      settle();
      check("b_c3_gnt",  b_gnt,  2'b01);
      check("b_c3_rvld", b_rvld, 2'b10);
      tick();
      b_req = 2'b10;
      b_set(1, 1'b0, 8'hFF, 10'd2, 64'd0);
      settle();
      check("b_c4_gnt",  b_gnt,  2'b10);
      check("b_c4_rvld", b_rvld, 2'b01);
      tick();
      b_req = 2'b01;
      b_set(0, 1'b0, 8'hFF, 10'd3, 64'd0);
      settle();
      check("b_c5_gnt",  b_gnt,   2'b01);
      check("b_c5_rvld", b_rvld,  2'b01);
      check("b_c5_data", b_rdata, D1);
      tick();
      b_req = '0;
      settle();
      check("b_c6_rvld", b_rvld,  2'b10);
      check("b_c6_data", b_rdata, D2);
      tick();
      settle();
      check("b_c7_rvld", b_rvld,  2'b01);
      check("b_c7_data", b_rdata, D3);
      tick();
      settle();
      check("b_c8_rvld", b_rvld,  2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
